// File: rtl/data_memory_be.sv
// Byte-addressed data memory for the RV32 MEM stage: byte-lane stores, extended
// loads with a registered one-cycle response, and fault flagging.
module data_memory_be #(
  parameter  int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Req,
  input  logic        i_wEnable,
  input  logic [1:0]  i_Size,
  input  logic        i_Unsigned,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_wData,
  output logic [31:0] o_rData,
  output logic        o_rValid,
  output logic        o_Fault,
  output logic        o_wDone
);
  localparam int NUM_LANES = 4;

  typedef logic [NUM_LANES-1:0][7:0] word_t;

  word_t [DEPTH-1:0] mem_q, mem_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              fault_q, fault_d;
  logic              wdone_q, wdone_d;

  logic [IDX_W-1:0]     idx;
  logic [1:0]           lane;
  logic                 oor, mis, bad;
  logic [NUM_LANES-1:0] be;
  logic [31:0]          wbytes;
  logic [31:0]          rd_word, ld_val;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;

  always_comb begin
    idx  = i_Addr[IDX_W+1:2];
    lane = i_Addr[1:0];
    oor  = |i_Addr[31:IDX_W+2];
    mis  = 1'b0;
    be   = '0;
    wbytes = i_wData;
    case (i_Size)
      2'b00: begin
        be     = NUM_LANES'(1) << lane;
        wbytes = {4{i_wData[7:0]}};
      end
      2'b01: begin
        mis    = i_Addr[0];
        be     = i_Addr[1] ? 4'b1100 : 4'b0011;
        wbytes = {2{i_wData[15:0]}};
      end
      2'b10: begin
        mis = |i_Addr[1:0];
        be  = 4'b1111;
      end
      default: mis = 1'b1;
    endcase
    bad = oor | mis;

    // Store data is replicated across lanes so each lane just picks its own byte.
    mem_d = mem_q;
    if (i_Req && i_wEnable && !bad) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (be[l]) mem_d[idx][l] = wbytes[8*l +: 8];
    end

    rd_word = mem_q[idx];
    byte_v  = rd_word[8*lane +: 8];
    half_v  = rd_word[16*i_Addr[1] +: 16];
    case (i_Size)
      2'b00:   ld_val = i_Unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   ld_val = i_Unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: ld_val = rd_word;
    endcase

    rvalid_d = i_Req && !i_wEnable && !bad;
    wdone_d  = i_Req && i_wEnable && !bad;
    fault_d  = i_Req && bad;
    rdata_d  = rvalid_d ? ld_val : rdata_q;
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      mem_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      wdone_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      fault_q  <= fault_d;
      wdone_q  <= wdone_d;
    end
  end

  assign o_rData  = rdata_q;
  assign o_rValid = rvalid_q;
  assign o_Fault  = fault_q;
  assign o_wDone  = wdone_q;
endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench for data_memory_be: each request pushes its expected response to
// a scoreboard queue, popped and checked one edge later.
module tb_data_memory_be;
  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_Req, i_wEnable, i_Unsigned;
  logic [1:0]  i_Size;
  logic [31:0] i_Addr, i_wData;
  logic [31:0] o_rData;
  logic        o_rValid, o_Fault, o_wDone;

  data_memory_be #(.DEPTH(64)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Req(i_Req), .i_wEnable(i_wEnable),
    .i_Size(i_Size), .i_Unsigned(i_Unsigned), .i_Addr(i_Addr), .i_wData(i_wData),
    .o_rData(o_rData), .o_rValid(o_rValid), .o_Fault(o_Fault), .o_wDone(o_wDone)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic        rvalid;
    logic        fault;
    logic        wdone;
    logic [31:0] rdata;
  } rsp_t;

  localparam logic [1:0] K_IDLE = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2, K_FAULT = 2'd3;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  rsp_t        sb_q[$];
  logic [31:0] last_rd;
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string tag, input rsp_t obs, input rsp_t exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s obs v/f/d=%b%b%b data=%h exp v/f/d=%b%b%b data=%h", tag,
                obs.rvalid, obs.fault, obs.wdone, obs.rdata,
                exp.rvalid, exp.fault, exp.wdone, exp.rdata);
  endtask

  // One request per cycle: drive on the falling edge, check just after the rising edge.
  task automatic step(input string tag, input logic req, we, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr, wd,
                      input logic [1:0] kind, input logic [31:0] exp_d);
    rsp_t e, obs;
    @(negedge i_Clk);
    i_Req = req; i_wEnable = we; i_Size = sz; i_Unsigned = uns;
    i_Addr = addr; i_wData = wd;
    if (kind == K_LOAD) last_rd = exp_d;
    e.rvalid = (kind == K_LOAD);
    e.fault  = (kind == K_FAULT);
    e.wdone  = (kind == K_STORE);
    e.rdata  = last_rd;
    sb_q.push_back(e);
    @(posedge i_Clk);
    #1;
    obs = '{o_rValid, o_Fault, o_wDone, o_rData};
    check(tag, obs, sb_q.pop_front());
  endtask

  task automatic ld(input string tag, input logic [1:0] sz, input logic uns,
                    input logic [31:0] addr, exp_d);
    step(tag, 1'b1, 1'b0, sz, uns, addr, 32'h0, K_LOAD, exp_d);
  endtask

  task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] addr, wd);
    step(tag, 1'b1, 1'b1, sz, 1'b0, addr, wd, K_STORE, 32'h0);
  endtask

  task automatic flt(input string tag, input logic we, input logic [1:0] sz,
                     input logic [31:0] addr);
    step(tag, 1'b1, we, sz, 1'b0, addr, 32'hCAFEF00D, K_FAULT, 32'h0);
  endtask

  initial begin
    rsp_t obs;
    i_Reset = 1'b0; i_Req = 1'b0; i_wEnable = 1'b0; i_Size = SZ_W;
    i_Unsigned = 1'b0; i_Addr = '0; i_wData = '0; last_rd = '0;
    #12;
    obs = '{o_rValid, o_Fault, o_wDone, o_rData};
    check("reset_state", obs, rsp_t'(0));
    @(negedge i_Clk);
    i_Reset = 1'b1;

    ld("lw_0x00_rst", SZ_W, 1'b0, 32'h00, 32'h0);
    ld("lw_0x04_rst", SZ_W, 1'b0, 32'h04, 32'h0);
    ld("lw_0xfc_rst", SZ_W, 1'b0, 32'hFC, 32'h0);

    st("sw_0x10", SZ_W, 32'h10, 32'h11223344);
    st("sb_0x11", SZ_B, 32'h11, 32'hFFFFFFAA);
    ld("lw_0x10", SZ_W, 1'b0, 32'h10, 32'h1122AA44);
    ld("lb_0x11", SZ_B, 1'b0, 32'h11, 32'hFFFFFFAA);
    ld("lbu_0x11", SZ_B, 1'b1, 32'h11, 32'h000000AA);
    ld("lb_0x13", SZ_B, 1'b0, 32'h13, 32'h00000011);
    ld("lh_0x10", SZ_H, 1'b0, 32'h10, 32'hFFFFAA44);
    step("idle_hold", 1'b0, 1'b0, SZ_X, 1'b0, 32'h10, 32'h0, K_IDLE, 32'h0);

    st("sh_0x22", SZ_H, 32'h22, 32'h12348001);
    ld("lh_0x22", SZ_H, 1'b0, 32'h22, 32'hFFFF8001);
    ld("lhu_0x22", SZ_H, 1'b1, 32'h22, 32'h00008001);
    ld("lw_0x20", SZ_W, 1'b0, 32'h20, 32'h80010000);

    flt("sw_0x13_mis", 1'b1, SZ_W, 32'h13);
    flt("lh_0x21_mis", 1'b0, SZ_H, 32'h21);
    flt("sz11_0x20", 1'b0, SZ_X, 32'h20);
    flt("lw_0x100_oor", 1'b0, SZ_W, 32'h100);
    flt("sw_0x100_oor", 1'b1, SZ_W, 32'h100);
    flt("sh_0x23_mis", 1'b1, SZ_H, 32'h23);
    ld("lw_0x10_kept", SZ_W, 1'b0, 32'h10, 32'h1122AA44);
    ld("lw_0x00_alias", SZ_W, 1'b0, 32'h00, 32'h0);
    ld("lw_0x20_kept", SZ_W, 1'b0, 32'h20, 32'h80010000);

    st("sw_0x30", SZ_W, 32'h30, 32'hDEADBEEF);
    ld("lw_0x30_b2b", SZ_W, 1'b0, 32'h30, 32'hDEADBEEF);
    ld("lbu_0x3c", SZ_B, 1'b1, 32'h3C, 32'h0);

    // Reset lands between a load's issue and its response edge.
    @(negedge i_Clk);
    i_Req = 1'b1; i_wEnable = 1'b0; i_Size = SZ_W; i_Addr = 32'h30;
    #2 i_Reset = 1'b0;
    @(posedge i_Clk);
    #1;
    obs = '{o_rValid, o_Fault, o_wDone, o_rData};
    check("rst_mid_load", obs, rsp_t'(0));
    @(negedge i_Clk);
    i_Req = 1'b0;
    i_Reset = 1'b1;
    last_rd = '0;

    ld("lw_0x30_after", SZ_W, 1'b0, 32'h30, 32'h0);
    ld("lw_0x10_after", SZ_W, 1'b0, 32'h10, 32'h0);
    ld("lw_0x20_after", SZ_W, 1'b0, 32'h20, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
